// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter between icache and dcache.
package ama_riscv_mem_arb_pkg;

  localparam int unsigned MEM_ADDR_BUS         = 12;
  localparam int unsigned MEM_DATA_BUS         = 128;
  localparam int unsigned MEM_TRANSFERS_PER_CL = 4;

  typedef enum logic {
    DMEM_READ  = 1'b0,
    DMEM_WRITE = 1'b1
  } dmem_rtype_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } mem_arb_src_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ama_riscv_rr_arb2.sv
// Two-way round-robin grant; bit 0 = icache, bit 1 = dcache. Purely combinational.
module ama_riscv_rr_arb2
  import ama_riscv_mem_arb_pkg::*;
(
  input  logic [1:0]   req,
  input  mem_arb_src_t last_gnt,
  input  logic         en,
  output logic [1:0]   gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // On a tie the requester that was not served last wins
      if (&req) gnt = (last_gnt == ARB_IC) ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Shares the single main-memory beat port between icache and dcache line transactions.
module ama_riscv_mem_arb
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int unsigned AW    = MEM_ADDR_BUS,
  parameter int unsigned DW    = MEM_DATA_BUS,
  parameter int unsigned BEATS = MEM_TRANSFERS_PER_CL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_req_valid,
  output logic          ic_req_ready,
  input  logic [AW-1:0] ic_req_addr,
  output logic          ic_rsp_valid,
  output logic [DW-1:0] ic_rsp_data,
  input  logic          dc_req_valid,
  output logic          dc_req_ready,
  input  dmem_rtype_t   dc_req_rtype,
  input  logic [AW-1:0] dc_req_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          dc_wdata_ack,
  output logic          dc_rsp_valid,
  output logic [DW-1:0] dc_rsp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data
);

  localparam int unsigned CW = $clog2(BEATS);
  localparam logic [CW-1:0] CntMax = CW'(BEATS - 1);

  if (!is_pow2(BEATS)) begin : gen_beats_chk
    $error("BEATS must be a power of two");
  end

  mem_arb_state_t   state_q, state_d;
  mem_arb_src_t     src_q, src_d;
  mem_arb_src_t     last_gnt_q, last_gnt_d;
  logic [CW-1:0]    req_cnt_q, req_cnt_d;
  logic [CW-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic             req_done_q, req_done_d;
  logic [AW-CW-1:0] line_q, line_d;

  logic [1:0] gnt;
  logic       mem_fire;
  logic       rsp_route;
  logic       proto_err;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{ic_req_addr[CW-1:0], dc_req_addr[CW-1:0]};

  // Held off during reset so no ready pulse escapes while rst is high
  ama_riscv_rr_arb2 u_rr_arb2 (
    .req      ({dc_req_valid, ic_req_valid}),
    .last_gnt (last_gnt_q),
    .en       ((state_q == ARB_IDLE) && !rst),
    .gnt      (gnt)
  );

  assign ic_req_ready = gnt[0];
  assign dc_req_ready = gnt[1];

  assign mem_req_valid = ((state_q == ARB_RD) && !req_done_q) || (state_q == ARB_WR);
  assign mem_req_we    = (state_q == ARB_WR);
  assign mem_req_addr  = mem_req_valid ? {line_q, req_cnt_q} : '0;
  assign mem_req_wdata = mem_req_we ? dc_wdata : '0;
  assign mem_fire      = mem_req_valid && mem_req_ready;
  assign dc_wdata_ack  = mem_req_we && mem_req_ready;

  // Responses outside a read line are dropped, never routed
  assign rsp_route    = (state_q == ARB_RD) && mem_rsp_valid;
  assign proto_err    = mem_rsp_valid && (state_q != ARB_RD);
  assign ic_rsp_valid = rsp_route && (src_q == ARB_IC);
  assign dc_rsp_valid = rsp_route && (src_q == ARB_DC);
  assign ic_rsp_data  = ic_rsp_valid ? mem_rsp_data : '0;
  assign dc_rsp_data  = dc_rsp_valid ? mem_rsp_data : '0;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    last_gnt_d = last_gnt_q;
    req_cnt_d  = req_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    req_done_d = req_done_q;
    line_d     = line_q;
    case (state_q)
      ARB_IDLE: begin
        if (|gnt) begin
          src_d      = gnt[1] ? ARB_DC : ARB_IC;
          last_gnt_d = gnt[1] ? ARB_DC : ARB_IC;
          line_d     = gnt[1] ? dc_req_addr[AW-1:CW] : ic_req_addr[AW-1:CW];
          req_cnt_d  = '0;
          rsp_cnt_d  = '0;
          req_done_d = 1'b0;
          state_d    = (gnt[1] && (dc_req_rtype == DMEM_WRITE)) ? ARB_WR : ARB_RD;
        end
      end
      ARB_RD: begin
        if (mem_fire) begin
          req_cnt_d = req_cnt_q + CW'(1);
          if (req_cnt_q == CntMax) req_done_d = 1'b1;
        end
        if (mem_rsp_valid) begin
          rsp_cnt_d = rsp_cnt_q + CW'(1);
          if (rsp_cnt_q == CntMax) state_d = ARB_IDLE;
        end
      end
      ARB_WR: begin
        if (mem_fire) begin
          req_cnt_d = req_cnt_q + CW'(1);
          if (req_cnt_q == CntMax) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      src_q      <= ARB_IC;
      last_gnt_q <= ARB_IC;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      req_done_q <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      last_gnt_q <= last_gnt_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      req_done_q <= req_done_d;
      line_q     <= line_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!proto_err) else $warning("mem_arb: stray memory response dropped");
  end

  ic_req_hold: assert property (@(posedge clk) disable iff (rst)
    ic_req_valid && !ic_req_ready |=> ic_req_valid);
  dc_req_hold: assert property (@(posedge clk) disable iff (rst)
    dc_req_valid && !dc_req_ready |=> dc_req_valid);

endmodule
